// File: rtl/video_attrib_pipe.sv
// Pipelined attribute/colour mux: per-dot attributes to a palette colour index,
// with internal vsync-driven cursor/character blink and sync carried at matched latency.
`timescale 1ns/1ps
module video_attrib_pipe #(
    parameter int PIX_W        = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_ce,
    input  logic [1:0]       mode,
    input  logic [7:0]       att_byte,
    input  logic [3:0]       pix_in,
    input  logic [5:0]       color_reg,
    input  logic             bw_mode,
    input  logic             blink_enabled,
    input  logic             cursor,
    input  logic             display_enable,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             pal_we,
    input  logic [3:0]       pal_addr,
    input  logic [PIX_W-1:0] pal_data,
    output logic [PIX_W-1:0] pix_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             overscan_out,
    output logic             cursor_phase,
    output logic             char_phase
);

    localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

    logic             vsync_q;
    logic [7:0]       frame_cnt;
    logic [PIX_W-1:0] palette [16];

    logic [3:0] s1_idx, idx_d;
    logic       s1_black, s1_ovs, s1_hs, s1_vs;
    logic       black_d, ovs_d, dot;

    // Blink runs on every clk so frame counting is independent of the pixel rate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q      <= 1'b0;
            frame_cnt    <= '0;
            cursor_phase <= 1'b0;
            char_phase   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (vsync && !vsync_q) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt    <= '0;
                    cursor_phase <= ~cursor_phase;
                    if (!cursor_phase)
                        char_phase <= ~char_phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    assign dot = (pix_in[0] & ~(blink_enabled & att_byte[7] & ~cursor & char_phase))
               | (cursor & cursor_phase);

    always_comb begin
        idx_d   = '0;
        black_d = 1'b0;
        ovs_d   = 1'b0;
        if (hsync || vsync) begin
            black_d = 1'b1;
        end else if (!display_enable) begin
            idx_d = color_reg[3:0];
            ovs_d = 1'b1;
        end else begin
            case (mode)
                2'b00: begin
                    if (dot)
                        idx_d = att_byte[3:0];
                    else if (blink_enabled)
                        idx_d = {1'b0, att_byte[6:4]};
                    else
                        idx_d = att_byte[7:4];
                end
                2'b01: begin
                    if (pix_in[1:0] == 2'b00)
                        idx_d = color_reg[3:0];
                    else
                        idx_d = {color_reg[4], pix_in[1], pix_in[0],
                                 bw_mode ? pix_in[0] : color_reg[5]};
                end
                2'b10:   idx_d = pix_in[0] ? color_reg[3:0] : 4'd0;
                default: idx_d = pix_in;
            endcase
        end
    end

    // Palette writes ignore pix_ce; a same-edge stage-2 read sees the old entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++)
                palette[i] <= PIX_W'(i);
        end else if (pal_we) begin
            palette[pal_addr] <= pal_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_idx       <= '0;
            s1_black     <= 1'b0;
            s1_ovs       <= 1'b0;
            s1_hs        <= 1'b0;
            s1_vs        <= 1'b0;
            pix_out      <= '0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            overscan_out <= 1'b0;
        end else if (pix_ce) begin
            s1_idx       <= idx_d;
            s1_black     <= black_d;
            s1_ovs       <= ovs_d;
            s1_hs        <= hsync;
            s1_vs        <= vsync;
            pix_out      <= s1_black ? '0 : palette[s1_idx];
            hsync_out    <= s1_hs;
            vsync_out    <= s1_vs;
            overscan_out <= s1_ovs;
        end
    end

endmodule

// File: tb/tb_video_attrib_pipe.sv
// Self-checking bench for video_attrib_pipe: directed scenarios plus randomized
// stimulus against a queue-based reference model (PIX_W=6, BLINK_FRAMES=2).
`timescale 1ns/1ps
module tb_video_attrib_pipe;

    localparam int PW = 6;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pix_ce = 1'b0;
    logic [1:0]    mode = '0;
    logic [7:0]    att_byte = '0;
    logic [3:0]    pix_in = '0;
    logic [5:0]    color_reg = '0;
    logic          bw_mode = 1'b0;
    logic          blink_enabled = 1'b0;
    logic          cursor = 1'b0;
    logic          display_enable = 1'b1;
    logic          hsync = 1'b0;
    logic          vsync = 1'b0;
    logic          pal_we = 1'b0;
    logic [3:0]    pal_addr = '0;
    logic [PW-1:0] pal_data = '0;
    logic [PW-1:0] pix_out;
    logic          hsync_out, vsync_out, overscan_out, cursor_phase, char_phase;

    int vectors = 0;
    int miscompares = 0;

    video_attrib_pipe #(.PIX_W(PW), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .mode(mode),
        .att_byte(att_byte), .pix_in(pix_in), .color_reg(color_reg),
        .bw_mode(bw_mode), .blink_enabled(blink_enabled), .cursor(cursor),
        .display_enable(display_enable), .hsync(hsync), .vsync(vsync),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .pix_out(pix_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .overscan_out(overscan_out), .cursor_phase(cursor_phase),
        .char_phase(char_phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] idx;
        logic       blk;
        logic       ovs;
        logic       hs;
        logic       vs;
    } rec_t;

    // Reference model: pixels in flight, palette contents, vsync edge count.
    rec_t          q[$];
    logic [PW-1:0] pal_m [16];
    int            edges;
    logic          vs_prev;
    logic [PW-1:0] exp_pix;
    logic          exp_hs, exp_vs, exp_ovs;

    function automatic logic m_cp();
        int k;
        k = edges / BF;
        return k[0];
    endfunction

    function automatic logic m_ch();
        int t;
        t = (edges / BF + 1) / 2;
        return t[0];
    endfunction

    function automatic rec_t model_rec();
        rec_t r;
        logic dot;
        r = '0;
        if (hsync || vsync) begin
            r.blk = 1'b1;
        end else if (!display_enable) begin
            r.idx = color_reg[3:0];
            r.ovs = 1'b1;
        end else begin
            case (mode)
                2'd0: begin
                    dot = (pix_in[0] && !(blink_enabled && att_byte[7] && !cursor && m_ch()))
                          || (cursor && m_cp());
                    if (dot) r.idx = att_byte[3:0];
                    else     r.idx = blink_enabled ? {1'b0, att_byte[6:4]} : att_byte[7:4];
                end
                2'd1: r.idx = (pix_in[1:0] == 2'b00) ? color_reg[3:0]
                            : {color_reg[4], pix_in[1], pix_in[0], bw_mode ? pix_in[0] : color_reg[5]};
                2'd2: r.idx = pix_in[0] ? color_reg[3:0] : 4'd0;
                default: r.idx = pix_in;
            endcase
        end
        r.hs = hsync;
        r.vs = vsync;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) pal_m[i] = PW'(i);
        q.delete();
        q.push_back('0);
        edges   = 0;
        vs_prev = 1'b0;
        exp_pix = '0;
        exp_hs  = 1'b0;
        exp_vs  = 1'b0;
        exp_ovs = 1'b0;
    endtask

    // One clock with the current inputs; model updated as of that edge.
    task automatic step(input logic pce);
        rec_t r;
        if (pce) begin
            r = q.pop_front();
            exp_pix = r.blk ? '0 : pal_m[r.idx];
            exp_hs  = r.hs;
            exp_vs  = r.vs;
            exp_ovs = r.ovs;
            q.push_back(model_rec());
        end
        if (pal_we) pal_m[pal_addr] = pal_data;
        if (vsync && !vs_prev) edges++;
        vs_prev = vsync;
        pix_ce  = pce;
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults();
        pix_ce = 0; mode = 0; att_byte = 0; pix_in = 0; color_reg = 0;
        bw_mode = 0; blink_enabled = 0; cursor = 0; display_enable = 1;
        hsync = 0; vsync = 0; pal_we = 0; pal_addr = 0; pal_data = 0;
    endtask

    task automatic do_reset();
        set_defaults();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        step(1'b1);
        vsync = 1'b0;
        step(1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        mode = 2'd3;
        for (int i = 0; i < 8; i++) begin
            pix_in = 4'($urandom);
            step(1'($urandom));
        end
        vsync = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({pix_out, hsync_out, vsync_out, overscan_out, cursor_phase, char_phase} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: outputs=%h required 0",
                     {pix_out, hsync_out, vsync_out, overscan_out, cursor_phase, char_phase});
        end
        for (int i = 0; i < 3; i++) begin
            pix_ce = ~pix_ce;
            pix_in = 4'($urandom);
            @(posedge clk);
            #1;
            vectors++;
            if ({pix_out, hsync_out, vsync_out, overscan_out, cursor_phase, char_phase} !== '0) begin
                miscompares++;
                $display("FAIL reset_held: outputs=%h required 0",
                         {pix_out, hsync_out, vsync_out, overscan_out, cursor_phase, char_phase});
            end
        end
        reset_n = 1'b1;
        model_reset();
        mode   = 2'd3;
        pix_in = 4'hA;
        step(1'b1);
        step(1'b1);
        vectors++;
        if (pix_out !== 6'h0A) begin
            miscompares++;
            $display("FAIL reset_palette_identity: pix_out=%h required 0a", pix_out);
        end
    endtask

    task automatic test_blink();
        do_reset();
        mode = 2'd0; att_byte = 8'h9F; pix_in = 4'h1; blink_enabled = 1'b1; cursor = 1'b0;
        vs_pulse(); vs_pulse();
        step(1'b1); step(1'b1);
        vectors++;
        if ({cursor_phase, char_phase, pix_out} !== {1'b1, 1'b1, 6'h01}) begin
            miscompares++;
            $display("FAIL blink_first: cp=%b ch=%b pix=%h required cp=1 ch=1 pix=01",
                     cursor_phase, char_phase, pix_out);
        end
        vs_pulse(); vs_pulse();
        step(1'b1); step(1'b1);
        vectors++;
        if ({cursor_phase, char_phase, pix_out} !== {1'b0, 1'b1, 6'h01}) begin
            miscompares++;
            $display("FAIL blink_second: cp=%b ch=%b pix=%h required cp=0 ch=1 pix=01",
                     cursor_phase, char_phase, pix_out);
        end
        vs_pulse(); vs_pulse();
        step(1'b1); step(1'b1);
        vectors++;
        if ({cursor_phase, char_phase, pix_out} !== {1'b1, 1'b0, 6'h0F}) begin
            miscompares++;
            $display("FAIL blink_third: cp=%b ch=%b pix=%h required cp=1 ch=0 pix=0f",
                     cursor_phase, char_phase, pix_out);
        end
        cursor = 1'b1; pix_in = 4'h0;
        step(1'b1); step(1'b1);
        vectors++;
        if (pix_out !== 6'h0F) begin
            miscompares++;
            $display("FAIL cursor_on: pix_out=%h required 0f", pix_out);
        end
        vs_pulse(); vs_pulse();
        step(1'b1); step(1'b1);
        vectors++;
        if ({cursor_phase, char_phase, pix_out} !== {1'b0, 1'b0, 6'h01}) begin
            miscompares++;
            $display("FAIL cursor_off: cp=%b ch=%b pix=%h required cp=0 ch=0 pix=01",
                     cursor_phase, char_phase, pix_out);
        end
    endtask

    task automatic test_four_color();
        logic [3:0] pat [3];
        logic       bw [3];
        logic [5:0] want [3];
        pat = '{4'b0011, 4'b0000, 4'b0010};
        bw  = '{1'b0, 1'b0, 1'b1};
        want = '{6'h0F, 6'h01, 6'h0C};
        do_reset();
        mode = 2'd1; color_reg = 6'b110001;
        for (int i = 0; i < 3; i++) begin
            pix_in = pat[i]; bw_mode = bw[i];
            step(1'b1); step(1'b1);
            vectors++;
            if (pix_out !== want[i]) begin
                miscompares++;
                $display("FAIL four_color_%0d: pix_out=%h required %h", i, pix_out, want[i]);
            end
        end
    endtask

    task automatic test_pal_collision();
        do_reset();
        mode = 2'd3; pix_in = 4'h5;
        step(1'b1);
        pal_we = 1'b1; pal_addr = 4'h5; pal_data = 6'h2A;
        step(1'b1);
        pal_we = 1'b0;
        vectors++;
        if (pix_out !== 6'h05) begin
            miscompares++;
            $display("FAIL pal_collision_old: pix_out=%h required 05", pix_out);
        end
        step(1'b1);
        vectors++;
        if (pix_out !== 6'h2A) begin
            miscompares++;
            $display("FAIL pal_collision_new: pix_out=%h required 2a", pix_out);
        end
    endtask

    task automatic test_sync_hold();
        do_reset();
        mode = 2'd3; pix_in = 4'h3;
        step(1'b1);
        hsync = 1'b1;
        step(1'b1);
        vectors++;
        if ({pix_out, hsync_out} !== {6'h03, 1'b0}) begin
            miscompares++;
            $display("FAIL hsync_latency1: pix=%h hs=%b required pix=03 hs=0", pix_out, hsync_out);
        end
        hsync = 1'b0;
        step(1'b1);
        vectors++;
        if ({pix_out, hsync_out} !== {6'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL hsync_latency2: pix=%h hs=%b required pix=00 hs=1", pix_out, hsync_out);
        end
        display_enable = 1'b0; color_reg = 6'h07;
        step(1'b1); step(1'b1);
        vectors++;
        if ({pix_out, overscan_out, hsync_out} !== {6'h07, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL overscan: pix=%h ovs=%b hs=%b required pix=07 ovs=1 hs=0",
                     pix_out, overscan_out, hsync_out);
        end
        display_enable = 1'b1; hsync = 1'b1; pix_in = 4'($urandom);
        pal_we = 1'b1; pal_addr = 4'h7; pal_data = 6'h3C;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            pal_we = 1'b0;
            vectors++;
            if ({pix_out, overscan_out, hsync_out} !== {6'h07, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL ce_hold_%0d: pix=%h ovs=%b hs=%b required pix=07 ovs=1 hs=0",
                         i, pix_out, overscan_out, hsync_out);
            end
        end
        hsync = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            mode           = 2'($urandom);
            att_byte       = 8'($urandom);
            pix_in         = 4'($urandom);
            color_reg      = 6'($urandom);
            bw_mode        = 1'($urandom);
            blink_enabled  = 1'($urandom);
            cursor         = ($urandom_range(0, 3) == 0);
            display_enable = ($urandom_range(0, 7) != 0);
            hsync          = ($urandom_range(0, 15) == 0);
            vsync          = ($urandom_range(0, 5) == 0);
            pal_we         = ($urandom_range(0, 7) == 0);
            pal_addr       = 4'($urandom);
            pal_data       = 6'($urandom);
            step($urandom_range(0, 3) != 0);
            vectors++;
            if ({pix_out, hsync_out, vsync_out, overscan_out} !== {exp_pix, exp_hs, exp_vs, exp_ovs}) begin
                miscompares++;
                $display("FAIL random_pixel n=%0d: pix=%h hs=%b vs=%b ovs=%b required pix=%h hs=%b vs=%b ovs=%b",
                         n, pix_out, hsync_out, vsync_out, overscan_out, exp_pix, exp_hs, exp_vs, exp_ovs);
            end
            vectors++;
            if ({cursor_phase, char_phase} !== {m_cp(), m_ch()}) begin
                miscompares++;
                $display("FAIL random_phase n=%0d: cp=%b ch=%b required cp=%b ch=%b",
                         n, cursor_phase, char_phase, m_cp(), m_ch());
            end
        end
        set_defaults();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_blink();
        test_four_color();
        test_pal_collision();
        test_sync_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_attrib_pipe.md
Name: video_attrib_pipe

Overview:
- Parametrised, pipelined successor to the CGA attribute/colour mux.
- Converts per-dot attribute, pixel and mode information into a final colour index from a programmable palette.
- Generates cursor and character blink phases internally from vsync, replacing the external blink input.
- Sits between the CRTC/sequencer pixel fetch and the DAC/scan-doubler. Carries sync alongside pixels with matched latency.

Parameters:
- PIX_W, 4, output colour width. Valid range 4..8; 6 gives EGA RGBrgb.
- BLINK_FRAMES, 8, vsync rising edges per cursor-phase toggle. Valid range 2..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pix_ce  in  1  pixel clock enable; the pipeline advances only when high
- mode  in  2  00 text, 01 graphics 4-colour, 10 graphics 2-colour, 11 graphics 16-colour direct
- att_byte  in  8  text attribute
- pix_in  in  4  text: bit0 = glyph dot; 4-colour: [1:0]; 2-colour: [0]; 16-colour: [3:0]
- color_reg  in  6  CGA colour-select register: [3:0] border/background, [4] intensity, [5] palette
- bw_mode  in  1  4-colour palette bit taken from pix_in[0] instead of color_reg[5]
- blink_enabled  in  1  attribute bit7 means blink, not background intensity
- cursor  in  1  current dot is inside the cursor
- display_enable  in  1  active display area
- hsync  in  1  horizontal sync (input timing)
- vsync  in  1  vertical sync (input timing)
- pal_we  in  1  palette write strobe
- pal_addr  in  4  palette entry to write
- pal_data  in  PIX_W  palette write data
- pix_out  out  PIX_W  final colour
- hsync_out  out  1  hsync delayed to match pix_out
- vsync_out  out  1  vsync delayed to match pix_out
- overscan_out  out  1  pix_out is the border colour
- cursor_phase  out  1  cursor blink phase
- char_phase  out  1  character blink phase

Behaviour:

Reset (reset_n low, asynchronous):
- All outputs 0.
- Pipeline registers 0, blink counter 0.
- Palette entry i = i, zero-extended to PIX_W.

Blink generator (runs every clk, independent of pix_ce):
- vsync is registered once; a rising edge increments the frame counter.
- When the counter reaches BLINK_FRAMES-1, the next edge wraps it to 0 and toggles cursor_phase.
- char_phase toggles on every 0->1 transition of cursor_phase, so it runs at half the cursor rate.

Stage 1 (on clk when pix_ce=1) registers idx[3:0], a force_black flag, an overscan flag, hsync and vsync:
- hsync|vsync high: force_black=1.
- Otherwise display_enable low: idx = color_reg[3:0], overscan=1.
- Text mode:
  - dot = (pix_in[0] & ~(blink_enabled & att_byte[7] & ~cursor & char_phase)) | (cursor & cursor_phase).
  - idx = att_byte[3:0] when dot=1.
  - When dot=0: idx = {1'b0, att_byte[6:4]} if blink_enabled, else att_byte[7:4].
- 4-colour mode:
  - pix_in[1:0]==0: idx = color_reg[3:0].
  - Otherwise idx = {color_reg[4], pix_in[1], pix_in[0], bw_mode ? pix_in[0] : color_reg[5]}.
- 2-colour mode: idx = pix_in[0] ? color_reg[3:0] : 0.
- 16-colour mode: idx = pix_in[3:0].

Stage 2 (on clk when pix_ce=1):
- pix_out = force_black ? 0 : palette[idx].
- hsync_out, vsync_out and overscan_out copy their stage-1 values.

Timing and hold:
- Latency is exactly 2 pix_ce strobes.
- With pix_ce=0, all pipeline registers and outputs hold.

Palette writes:
- On clk when pal_we=1, independent of pix_ce; visible from the following clk.
- A write and a stage-2 read of the same entry on the same edge: the read returns the old value.

Mode changes:
- Take effect on the next pix_ce. Pixels already in flight are not altered.

Test Plan:
- Reset: hold reset_n low mid-frame with pix_ce toggling -> all outputs 0. After release, palette reads identity: mode 11, pix_in=4'hA -> pix_out=0xA two strobes later.
- Text blink, BLINK_FRAMES=2, att_byte=8'h9F, pix_in[0]=1, blink_enabled=1, cursor=0:
  - After 2 vsync rising edges, cursor_phase=1, char_phase=1, and pix_out = 1 (background, att[6:4]=001).
  - After 2 further edges, char_phase holds and cursor_phase=0.
  - After another 2 edges, char_phase=0 and pix_out=0xF.
- Cursor: cursor=1, pix_in[0]=0, cursor_phase=1 -> pix_out=att_byte[3:0]. With cursor_phase=0 -> pix_out=background.
- 4-colour mode, color_reg=6'b110001:
  - pix_in=2'b11 -> idx=0xF.
  - pix_in=0 -> idx=0x1.
  - bw_mode=1, pix_in=2'b10 -> idx=0xC.
- Palette write collision: PIX_W=6, write pal_addr=5, pal_data=6'h2A on the same edge a stage-2 read of idx 5 occurs -> that pixel outputs 0x05, the next pixel with idx 5 outputs 0x2A.
- Sync/blank and pix_ce hold:
  - hsync=1 -> pix_out=0 and hsync_out=1 exactly 2 strobes later.
  - display_enable=0 -> pix_out=palette[color_reg[3:0]] with overscan_out=1.
  - Insert 3 idle clocks with pix_ce=0 -> outputs unchanged.
